pwm_duty_meter: RTL and testbench

Measures an incoming PWM waveform, such as the LED drive produced by the breathing-light generator or any external PWM source. It reports the high time and the period in clock cycles, once per PWM period. The block sits on the capture side of PWM links: loopback self-test of the LED driver, fan/servo feedback, and duty readback to a status register. It also flags a stuck input (no edge for a programmable time).

---
 rtl/pwm_duty_meter.sv | 170 +++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// PWM capture: reports high time and period in clk cycles once per PWM period and flags a stuck input.
// Optional glitch filter between synchronizer and edge detector: define PWM_METER_GLITCH_FILTER_EN.
module pwm_duty_meter #(
  parameter int          CNT_W    = 20,
  parameter int unsigned TIMEOUT  = 1_000_000,
  parameter int          FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             level_stuck,
  output logic             stuck_level,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEAS  = 2'd1,
    S_STUCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam bit CFG_OK = (FILT_LEN >= 2) && (FILT_LEN <= 15) &&
                          (64'(TIMEOUT) < ((64'(1) << CNT_W) - 64'(1)));

  if (!CFG_OK) begin : g_cfg_err
    $error("pwm_duty_meter: FILT_LEN must be 2..15 and TIMEOUT < 2^CNT_W-1");
  end

  logic sync1_q, pwm_s_q, pwm_d_q;
  logic lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      pwm_s_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      pwm_s_q <= sync1_q;
    end
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  // The filtered level follows pwm_s only after FILT_LEN consecutive disagreeing samples.
  logic       filt_q;
  logic [3:0] run_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b0;
      run_q  <= 4'd0;
    end else if (pwm_s_q == filt_q) begin
      run_q <= 4'd0;
    end else if (run_q == 4'(FILT_LEN - 1)) begin
      filt_q <= pwm_s_q;
      run_q  <= 4'd0;
    end else begin
      run_q <= run_q + 4'd1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = pwm_s_q;
`endif

  logic rise, fall, timeout_hit;
  assign rise        = lvl & ~pwm_d_q;
  assign fall        = ~lvl & pwm_d_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_cnt_q, high_d;
  logic [CNT_W-1:0] period_cnt_q, period_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;

  // >= rather than == so an edge landing exactly on TIMEOUT cannot let cnt run past it and wrap.
  assign timeout_hit = (cnt_q >= TO_CNT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + ONE;
    hi_lat_d    = hi_lat_q;
    high_d      = high_cnt_q;
    period_d    = period_cnt_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    if (rise) cnt_d = ONE;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_MEAS;
        end else if (fall) begin
          cnt_d = '0;
        end else if (timeout_hit) begin
          state_d     = S_STUCK;
          stuck_d     = 1'b1;
          stuck_lvl_d = lvl;
        end
      end
      S_MEAS: begin
        if (rise) begin
          high_d   = hi_lat_q;
          period_d = cnt_q;
          valid_d  = 1'b1;
        end else if (fall) begin
          hi_lat_d = cnt_q;
        end else if (timeout_hit) begin
          state_d     = S_STUCK;
          stuck_d     = 1'b1;
          stuck_lvl_d = lvl;
        end
      end
      S_STUCK: begin
        cnt_d = cnt_q;
        if (rise) begin
          cnt_d   = ONE;
          stuck_d = 1'b0;
          state_d = S_MEAS;
        end else if (fall) begin
          cnt_d   = '0;
          stuck_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_d_q      <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hi_lat_q     <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      stuck_lvl_q  <= 1'b0;
    end else begin
      pwm_d_q      <= lvl;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_lat_q     <= hi_lat_d;
      high_cnt_q   <= high_d;
      period_cnt_q <= period_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      stuck_lvl_q  <= stuck_lvl_d;
    end
  end

  // meas_valid is a one-cycle strobe with no ready; high_cnt/period_cnt are valid with it and hold until the next one.
  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign meas_valid  = valid_q;
  assign level_stuck = stuck_q;
  assign stuck_level = stuck_lvl_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: pulse table, latency/stuck/reset/glitch sequences and random PWM vs. a pulse-level model.
module tb_pwm_duty_meter;
  localparam int CNT_W    = 20;
  localparam int TIMEOUT  = 400;
  localparam int FILT_LEN = 4;
`ifdef PWM_METER_GLITCH_FILTER_EN
  localparam int FL = FILT_LEN;
`else
  localparam int FL = 0;
`endif
  localparam int W  = 2 * CNT_W;
  localparam int NV = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             meas_valid, level_stuck, stuck_level;
  logic [1:0]       state_o;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .meas_valid(meas_valid),
    .level_stuck(level_stuck), .stuck_level(stuck_level), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;
  int pushes = 0;
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_hi_last = '0;
  logic [CNT_W-1:0] exp_per_last = '0;
  bit armed = 1'b0;
  int prev_hi = 0;
  int prev_lo = 0;

  typedef struct {
    int               hi;
    int               lo;
    logic [CNT_W-1:0] exp_hi;
    logic [CNT_W-1:0] exp_per;
  } vec_t;
  vec_t tbl[NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected measurement; outputs must hold in between.
  always @(negedge clk) begin
    if (rst) begin
      if (meas_valid === 1'b1) begin
        pulses_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_meas: got high %0d period %0d, expected no pulse", high_cnt, period_cnt);
        end else begin
          {exp_hi_last, exp_per_last} = exp_q.pop_front();
        end
      end
      check("high_cnt", 64'(high_cnt), 64'(exp_hi_last));
      check("period_cnt", 64'(period_cnt), 64'(exp_per_last));
    end
  end

  task automatic seg(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_prev();
    if (armed) begin
      exp_q.push_back({CNT_W'(prev_hi), CNT_W'(prev_hi + prev_lo)});
      pushes++;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    push_prev();
    seg(1'b1, hi);
    seg(1'b0, lo);
    armed = 1'b1;
    prev_hi = hi;
    prev_lo = lo;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    pwm_in = 1'b0;
    #1;
    check("rst_high_cnt", 64'(high_cnt), 0);
    check("rst_period_cnt", 64'(period_cnt), 0);
    check("rst_meas_valid", 64'(meas_valid), 0);
    check("rst_level_stuck", 64'(level_stuck), 0);
    check("rst_stuck_level", 64'(stuck_level), 0);
    check("queue_empty_at_reset", 64'(exp_q.size()), 0);
    exp_q.delete();
    exp_hi_last = '0;
    exp_per_last = '0;
    armed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic rise_latency(input int hi, input int lo);
    int k;
    bit found;
    push_prev();
    pwm_in = 1'b1;
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      @(negedge clk);
      k++;
      if (meas_valid === 1'b1) found = 1'b1;
    end
    check("meas_latency", 64'(k), 64'(4 + FL));
    @(posedge clk);
    repeat (hi - k) @(posedge clk);
    #1;
    seg(1'b0, lo);
    armed = 1'b1;
    prev_hi = hi;
    prev_lo = lo;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tbl[0] = '{30, 70, 30, 100};
    tbl[1] = '{30, 70, 30, 100};
    tbl[2] = '{30, 70, 30, 100};
    tbl[3] = '{70, 30, 70, 100};
    tbl[4] = '{70, 30, 70, 100};
    tbl[5] = '{45, 55, 45, 100};
    tbl[6] = '{10, 20, 10, 30};
    tbl[7] = '{5, 5, 5, 10};
    tbl[8] = '{100, 150, 100, 250};
    tbl[9] = '{30, 70, 30, 100};

    do_reset();

    // Table: the first rise after reset yields nothing, each later rise reports the previous pulse.
    for (int i = 0; i < NV; i++) begin
      if (i > 0) begin
        exp_q.push_back({tbl[i-1].exp_hi, tbl[i-1].exp_per});
        pushes++;
      end
      seg(1'b1, tbl[i].hi);
      seg(1'b0, tbl[i].lo);
    end
    exp_q.push_back({tbl[NV-1].exp_hi, tbl[NV-1].exp_per});
    pushes++;
    rise_latency(30, 70);

    // Input held high after a rise: stuck high after TIMEOUT+1 cycles, results held.
    pulse(30, 70);
    push_prev();
    pwm_in = 1'b1;
    k = 0;
    while (level_stuck !== 1'b1 && k < TIMEOUT + 50) begin
      @(negedge clk);
      k++;
    end
    check("stuck_high_delay", 64'(k), 64'(TIMEOUT + 4 + FL));
    check("stuck_high_level", 64'(stuck_level), 1);
    check("stuck_hold_high_cnt", 64'(high_cnt), 30);
    check("stuck_hold_period_cnt", 64'(period_cnt), 100);
    @(posedge clk);
    #1;
    seg(1'b0, 8 + FL);
    check("stuck_cleared_by_fall", 64'(level_stuck), 0);
    armed = 1'b0;
    pulse(30, 70);
    pulse(40, 60);
    pulse(30, 70);

    // Reset in the middle of a high phase.
    push_prev();
    pwm_in = 1'b1;
    repeat (15) @(posedge clk);
    do_reset();
    pulse(30, 70);
    pulse(30, 70);

    // Two-cycle glitch inside a 100-cycle low phase.
    pulse(30, 40);
`ifdef PWM_METER_GLITCH_FILTER_EN
    seg(1'b1, 2);
    seg(1'b0, 58);
    prev_lo = 40 + 2 + 58;
`else
    pulse(2, 58);
`endif
    pulse(30, 70);
    pulse(30, 70);

    // Low from reset: stuck low after TIMEOUT+1 cycles, cleared by the next rise.
    do_reset();
    k = 0;
    while (level_stuck !== 1'b1 && k < TIMEOUT + 50) begin
      @(negedge clk);
      k++;
    end
    check("stuck_low_delay", 64'(k), 64'(TIMEOUT + 2));
    check("stuck_low_level", 64'(stuck_level), 0);
    pwm_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("stuck_cleared_by_rise", 64'(level_stuck), 0);
    seg(1'b1, 20);
    seg(1'b0, 70);
    armed = 1'b1;
    prev_hi = 30;
    prev_lo = 70;

    // Random PWM against the pulse-level model.
    for (int i = 0; i < 40; i++) begin
      pulse(int'($urandom_range(5, 120)), int'($urandom_range(5, 120)));
    end
    pulse(30, 70);
    seg(1'b0, 20);

    check("queue_drained", 64'(exp_q.size()), 0);
    check("pulse_count", 64'(pulses_seen), 64'(pushes));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
